// File: rtl/iob_cache_wtb_drain_pkg.sv
// ----------------------------------------------------------------------------
// iob_cache_wtb_drain_pkg
// Shared definitions for the write-through-buffer drain sequencer:
//   - state_e        : 3-bit FSM state encoding
//   - wtb_*_off()    : bit offsets of the {addr,wdata,wstrb} fields inside a
//                      WTB entry (wstrb in the LSBs)
//   - PERF_*         : indices of the optional performance counters
// ----------------------------------------------------------------------------
package iob_cache_wtb_drain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_POP  = 3'd1,
        ST_WR_REQ  = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_WAIT = 3'd4
    } state_e;

    localparam int PERF_CNT_W = 32;
    localparam int PERF_N     = 3;
    localparam int PERF_WR    = 0;
    localparam int PERF_RD    = 1;
    localparam int PERF_STALL = 2;

    // WTB entry layout: [addr | wdata | wstrb], wstrb at bit 0.
    function automatic int wtb_wstrb_off();
        return 0;
    endfunction

    function automatic int wtb_wdata_off(input int nbytes);
        return nbytes;
    endfunction

    function automatic int wtb_addr_off(input int nbytes, input int data_w);
        return nbytes + data_w;
    endfunction

endpackage

// File: rtl/iob_cache_sat_cnt.sv
// ----------------------------------------------------------------------------
// iob_cache_sat_cnt
// Saturating up-counter with enable; sticks at all-ones.
// Ports:
//   clk_i    in  clock
//   arst_n_i in  asynchronous reset, active low (clears the count)
//   en_i     in  count enable (one increment per enabled cycle)
//   cnt_o    out current count
// ----------------------------------------------------------------------------
module iob_cache_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/iob_cache_wtb_drain.sv
// ----------------------------------------------------------------------------
// iob_cache_wtb_drain
// Back-end sequencer behind the cache write-through buffer. Pops WTB entries
// and issues them as IOb writes, and issues line-refill reads on the same IOb
// master port. The WTB is always drained before a refill starts, so a refill
// observes every earlier buffered write.
//
// Optional feature macro: IOB_CACHE_WTB_DRAIN_PERF_EN adds three saturating
// 32-bit performance counters (write beats, refills, request stall cycles).
//
// Ports:
//   clk_i, arst_n_i, cke_i   clock, async active-low reset, clock enable
//   wtb_rdata_i/empty_i/ren_o WTB FIFO read side (data valid 1 cycle after pop)
//   refill_req_i/addr_i      1-cycle refill request with line address
//   refill_busy_o            refill accepted and not yet finished
//   refill_valid/word/data/done_o  registered refill word stream
//   be_*                     IOb master (wstrb==0 means read)
//   perf_*_cnt_o             performance counters (feature macro only)
//   idle_o                   nothing to do and nothing in flight
// ----------------------------------------------------------------------------
module iob_cache_wtb_drain
    import iob_cache_wtb_drain_pkg::*;
#(
    parameter  int BE_ADDR_W  = 32,
    parameter  int BE_DATA_W  = 32,
    parameter  int WORD_OFF_W = 2,
    localparam int BE_NBYTES  = BE_DATA_W / 8,
    localparam int WTB_DATA_W = BE_ADDR_W + BE_DATA_W + BE_NBYTES,
    localparam int BYTE_OFF_W = $clog2(BE_NBYTES),
    localparam int LINE_W     = BE_ADDR_W - WORD_OFF_W - BYTE_OFF_W
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic                  cke_i,
    input  logic [WTB_DATA_W-1:0] wtb_rdata_i,
    input  logic                  wtb_empty_i,
    output logic                  wtb_ren_o,
    input  logic                  refill_req_i,
    input  logic [LINE_W-1:0]     refill_addr_i,
    output logic                  refill_busy_o,
    output logic                  refill_valid_o,
    output logic [WORD_OFF_W-1:0] refill_word_o,
    output logic [BE_DATA_W-1:0]  refill_data_o,
    output logic                  refill_done_o,
    output logic                  be_avalid_o,
    output logic [BE_ADDR_W-1:0]  be_addr_o,
    output logic [BE_DATA_W-1:0]  be_wdata_o,
    output logic [BE_NBYTES-1:0]  be_wstrb_o,
    input  logic [BE_DATA_W-1:0]  be_rdata_i,
    input  logic                  be_rvalid_i,
    input  logic                  be_ready_i,
`ifdef IOB_CACHE_WTB_DRAIN_PERF_EN
    output logic [31:0]           perf_wr_cnt_o,
    output logic [31:0]           perf_rd_cnt_o,
    output logic [31:0]           perf_stall_cnt_o,
`endif
    output logic                  idle_o
);

    localparam int STRB_OFF = wtb_wstrb_off();
    localparam int DATA_OFF = wtb_wdata_off(BE_NBYTES);
    localparam int ADDR_OFF = wtb_addr_off(BE_NBYTES, BE_DATA_W);

    state_e                  state_q, state_d;
    logic                    be_avalid_q, be_avalid_d;
    logic [BE_ADDR_W-1:0]    be_addr_q, be_addr_d;
    logic [BE_DATA_W-1:0]    be_wdata_q, be_wdata_d;
    logic [BE_NBYTES-1:0]    be_wstrb_q, be_wstrb_d;
    logic                    pending_q, pending_d;
    logic                    busy_q, busy_d;
    logic [LINE_W-1:0]       line_q, line_d;
    logic [WORD_OFF_W-1:0]   word_cnt_q, word_cnt_d;
    logic                    refill_valid_q, refill_valid_d;
    logic [WORD_OFF_W-1:0]   refill_word_q, refill_word_d;
    logic [BE_DATA_W-1:0]    refill_data_q, refill_data_d;
    logic                    refill_done_q, refill_done_d;
    logic                    ren_c;
    logic [WORD_OFF_W-1:0]   word_nxt;

    assign word_nxt = word_cnt_q + WORD_OFF_W'(1);

    always_comb begin
        state_d        = state_q;
        be_avalid_d    = be_avalid_q;
        be_addr_d      = be_addr_q;
        be_wdata_d     = be_wdata_q;
        be_wstrb_d     = be_wstrb_q;
        pending_d      = pending_q;
        busy_d         = busy_q;
        line_d         = line_q;
        word_cnt_d     = word_cnt_q;
        refill_valid_d = 1'b0;
        refill_word_d  = refill_word_q;
        refill_data_d  = refill_data_q;
        refill_done_d  = 1'b0;
        ren_c          = 1'b0;

        // Requests arriving while busy are dropped.
        if (refill_req_i && !busy_q) begin
            pending_d = 1'b1;
            busy_d    = 1'b1;
            line_d    = refill_addr_i;
        end
        // Busy covers the registered done pulse, so it falls one cycle later.
        if (refill_done_q) begin
            busy_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                // Buffered writes always win over a pending refill.
                if (!wtb_empty_i) begin
                    ren_c   = 1'b1;
                    state_d = ST_WR_POP;
                end else if (pending_q) begin
                    be_avalid_d = 1'b1;
                    be_addr_d   = {line_q, word_cnt_q, {BYTE_OFF_W{1'b0}}};
                    be_wdata_d  = '0;
                    be_wstrb_d  = '0;
                    state_d     = ST_RD_REQ;
                end
            end
            ST_WR_POP: begin
                be_avalid_d = 1'b1;
                be_addr_d   = wtb_rdata_i[ADDR_OFF +: BE_ADDR_W];
                be_wdata_d  = wtb_rdata_i[DATA_OFF +: BE_DATA_W];
                be_wstrb_d  = wtb_rdata_i[STRB_OFF +: BE_NBYTES];
                state_d     = ST_WR_REQ;
            end
            ST_WR_REQ: begin
                if (be_ready_i) begin
                    be_avalid_d = 1'b0;
                    if (!wtb_empty_i) begin
                        ren_c   = 1'b1;
                        state_d = ST_WR_POP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RD_REQ: begin
                if (be_ready_i) begin
                    be_avalid_d = 1'b0;
                    state_d     = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (be_rvalid_i) begin
                    refill_valid_d = 1'b1;
                    refill_data_d  = be_rdata_i;
                    refill_word_d  = word_cnt_q;
                    word_cnt_d     = word_nxt;
                    if (word_cnt_q == {WORD_OFF_W{1'b1}}) begin
                        refill_done_d = 1'b1;
                        pending_d     = 1'b0;
                        state_d       = ST_IDLE;
                    end else begin
                        be_avalid_d = 1'b1;
                        be_addr_d   = {line_q, word_nxt, {BYTE_OFF_W{1'b0}}};
                        state_d     = ST_RD_REQ;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q        <= ST_IDLE;
            be_avalid_q    <= 1'b0;
            be_addr_q      <= '0;
            be_wdata_q     <= '0;
            be_wstrb_q     <= '0;
            pending_q      <= 1'b0;
            busy_q         <= 1'b0;
            line_q         <= '0;
            word_cnt_q     <= '0;
            refill_valid_q <= 1'b0;
            refill_word_q  <= '0;
            refill_data_q  <= '0;
            refill_done_q  <= 1'b0;
        end else if (cke_i) begin
            state_q        <= state_d;
            be_avalid_q    <= be_avalid_d;
            be_addr_q      <= be_addr_d;
            be_wdata_q     <= be_wdata_d;
            be_wstrb_q     <= be_wstrb_d;
            pending_q      <= pending_d;
            busy_q         <= busy_d;
            line_q         <= line_d;
            word_cnt_q     <= word_cnt_d;
            refill_valid_q <= refill_valid_d;
            refill_word_q  <= refill_word_d;
            refill_data_q  <= refill_data_d;
            refill_done_q  <= refill_done_d;
        end
    end

    // A frozen FSM must not consume FIFO entries.
    assign wtb_ren_o      = cke_i & ren_c;
    assign refill_busy_o  = busy_q;
    assign refill_valid_o = refill_valid_q;
    assign refill_word_o  = refill_word_q;
    assign refill_data_o  = refill_data_q;
    assign refill_done_o  = refill_done_q;
    assign be_avalid_o    = be_avalid_q;
    assign be_addr_o      = be_addr_q;
    assign be_wdata_o     = be_wdata_q;
    assign be_wstrb_o     = be_wstrb_q;
    assign idle_o         = (state_q == ST_IDLE) & wtb_empty_i & ~pending_q & ~busy_q;

    // The controller must never request a refill while one is in progress.
    always @(posedge clk_i) begin
        if (cke_i && refill_req_i) begin
            assert (!busy_q);
        end
    end

`ifdef IOB_CACHE_WTB_DRAIN_PERF_EN
    logic [PERF_N-1:0]     perf_en;
    logic [PERF_CNT_W-1:0] perf_cnt [PERF_N];

    assign perf_en[PERF_WR]    = cke_i & (state_q == ST_WR_REQ) & be_ready_i;
    // done_q stays set while clock-disabled, so only enabled cycles count.
    assign perf_en[PERF_RD]    = cke_i & refill_done_q;
    assign perf_en[PERF_STALL] = cke_i & be_avalid_q & ~be_ready_i;

    genvar gi;
    generate
        for (gi = 0; gi < PERF_N; gi++) begin : g_perf
            iob_cache_sat_cnt #(
                .CNT_W(PERF_CNT_W)
            ) u_cnt (
                .clk_i   (clk_i),
                .arst_n_i(arst_n_i),
                .en_i    (perf_en[gi]),
                .cnt_o   (perf_cnt[gi])
            );
        end
    endgenerate

    assign perf_wr_cnt_o    = perf_cnt[PERF_WR];
    assign perf_rd_cnt_o    = perf_cnt[PERF_RD];
    assign perf_stall_cnt_o = perf_cnt[PERF_STALL];
`endif

endmodule

// File: tb/tb_iob_cache_wtb_drain.sv
// ----------------------------------------------------------------------------
// tb_iob_cache_wtb_drain
// Directed bench for iob_cache_wtb_drain: a WTB FIFO model, an IOb slave with
// programmable stall and read latency (rdata = addr ^ 0xC0DE0000), and a
// monitor that logs every bus transaction. Expected values are hand-computed.
// ----------------------------------------------------------------------------
module tb_iob_cache_wtb_drain;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        cke;
    logic [67:0] wtb_rdata_i;
    logic        wtb_empty_i;
    logic        wtb_ren_o;
    logic        refill_req;
    logic [27:0] refill_addr;
    logic        refill_busy_o;
    logic        refill_valid_o;
    logic [1:0]  refill_word_o;
    logic [31:0] refill_data_o;
    logic        refill_done_o;
    logic        be_avalid_o;
    logic [31:0] be_addr_o;
    logic [31:0] be_wdata_o;
    logic [3:0]  be_wstrb_o;
    logic [31:0] be_rdata_i;
    logic        be_rvalid_i;
    logic        be_ready_i;
    logic        idle_o;
`ifdef IOB_CACHE_WTB_DRAIN_PERF_EN
    logic [31:0] perf_wr_cnt_o;
    logic [31:0] perf_rd_cnt_o;
    logic [31:0] perf_stall_cnt_o;
`endif

    always #5 clk = ~clk;

    iob_cache_wtb_drain dut (
        .clk_i           (clk),
        .arst_n_i        (arst_n),
        .cke_i           (cke),
        .wtb_rdata_i     (wtb_rdata_i),
        .wtb_empty_i     (wtb_empty_i),
        .wtb_ren_o       (wtb_ren_o),
        .refill_req_i    (refill_req),
        .refill_addr_i   (refill_addr),
        .refill_busy_o   (refill_busy_o),
        .refill_valid_o  (refill_valid_o),
        .refill_word_o   (refill_word_o),
        .refill_data_o   (refill_data_o),
        .refill_done_o   (refill_done_o),
        .be_avalid_o     (be_avalid_o),
        .be_addr_o       (be_addr_o),
        .be_wdata_o      (be_wdata_o),
        .be_wstrb_o      (be_wstrb_o),
        .be_rdata_i      (be_rdata_i),
        .be_rvalid_i     (be_rvalid_i),
        .be_ready_i      (be_ready_i),
`ifdef IOB_CACHE_WTB_DRAIN_PERF_EN
        .perf_wr_cnt_o   (perf_wr_cnt_o),
        .perf_rd_cnt_o   (perf_rd_cnt_o),
        .perf_stall_cnt_o(perf_stall_cnt_o),
`endif
        .idle_o          (idle_o)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // ---------------- WTB FIFO model ----------------
    logic [67:0] fifo_mem [32];
    int fifo_wr = 0;
    int fifo_rd = 0;

    assign wtb_empty_i = (fifo_wr == fifo_rd);

    always @(posedge clk) begin
        if (wtb_ren_o) begin
            wtb_rdata_i <= fifo_mem[fifo_rd % 32];
            fifo_rd     <= fifo_rd + 1;
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        fifo_mem[fifo_wr % 32] = {a, d, s};
        fifo_wr++;
    endtask

    // ---------------- IOb slave model ----------------
    int stall_n  = 0;
    int rv_delay = 3;
    int stall_ctr;
    int rd_cnt;
    logic [31:0] rd_addr_lat;

    always @(negedge clk) begin
        if (!arst_n) begin
            rd_cnt      = 0;
            stall_ctr   = 0;
            be_rvalid_i = 1'b0;
            be_ready_i  = 1'b0;
        end else begin
            be_rvalid_i = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    be_rvalid_i = 1'b1;
                    be_rdata_i  = rd_addr_lat ^ 32'hC0DE0000;
                end
            end
            be_ready_i = 1'b0;
            if (be_avalid_o) begin
                if (stall_ctr < stall_n) begin
                    stall_ctr++;
                end else begin
                    be_ready_i = 1'b1;
                    stall_ctr  = 0;
                    if (be_wstrb_o == 4'h0) begin
                        rd_cnt      = rv_delay;
                        rd_addr_lat = be_addr_o;
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];
    logic [3:0]  wr_strb [64];
    int          wr_cyc  [64];
    int          wr_n = 0;
    logic [31:0] rd_addr [64];
    int          rd_cyc  [64];
    int          rd_n = 0;
    logic [1:0]  rv_word [64];
    logic [31:0] rv_data [64];
    logic        rv_done [64];
    logic        rv_busy [64];
    int          rv_n = 0;
    int          done_n = 0;
    int          pop_cyc [64];
    int          pop_n = 0;
    int          hold_cnt = 0;
    int          hold_max = 0;
    int          hold_bad = 0;
    logic [67:0] hold_val;

    always @(negedge clk) begin
        #1;
        if (arst_n) begin
            if (wtb_ren_o && pop_n < 64) begin
                pop_cyc[pop_n] = cyc;
                pop_n++;
            end
            if (be_avalid_o && be_ready_i) begin
                if (be_wstrb_o != 4'h0 && wr_n < 64) begin
                    wr_addr[wr_n] = be_addr_o;
                    wr_data[wr_n] = be_wdata_o;
                    wr_strb[wr_n] = be_wstrb_o;
                    wr_cyc[wr_n]  = cyc;
                    $display("write  cyc=%0d addr=0x%08h data=0x%08h strb=0x%0h", cyc, be_addr_o, be_wdata_o, be_wstrb_o);
                    wr_n++;
                end else if (be_wstrb_o == 4'h0 && rd_n < 64) begin
                    rd_addr[rd_n] = be_addr_o;
                    rd_cyc[rd_n]  = cyc;
                    $display("read   cyc=%0d addr=0x%08h", cyc, be_addr_o);
                    rd_n++;
                end
            end
            if (be_avalid_o && !be_ready_i) begin
                if (hold_cnt == 0) begin
                    hold_val = {be_addr_o, be_wdata_o, be_wstrb_o};
                end else if (hold_val !== {be_addr_o, be_wdata_o, be_wstrb_o}) begin
                    hold_bad++;
                end
                hold_cnt++;
                if (hold_cnt > hold_max) hold_max = hold_cnt;
            end else begin
                hold_cnt = 0;
            end
            if (refill_valid_o && rv_n < 64) begin
                rv_word[rv_n] = refill_word_o;
                rv_data[rv_n] = refill_data_o;
                rv_done[rv_n] = refill_done_o;
                rv_busy[rv_n] = refill_busy_o;
                $display("refill cyc=%0d word=%0d data=0x%08h done=%0b", cyc, refill_word_o, refill_data_o, refill_done_o);
                rv_n++;
            end
            if (refill_done_o) done_n++;
        end
    end

    // ---------------- bounded waits ----------------
    task automatic wait_wr(input int target, input string tag);
        for (int i = 0; i < 500; i++) begin
            if (wr_n >= target) break;
            @(posedge clk);
        end
        chk(tag, 64'(wr_n >= target), 64'd1);
    endtask

    task automatic wait_rd(input int target, input string tag);
        for (int i = 0; i < 500; i++) begin
            if (rd_n >= target) break;
            @(posedge clk);
        end
        chk(tag, 64'(rd_n >= target), 64'd1);
    endtask

    task automatic wait_done(input int target, input string tag);
        for (int i = 0; i < 500; i++) begin
            if (done_n >= target) break;
            @(posedge clk);
        end
        chk(tag, 64'(done_n >= target), 64'd1);
    endtask

    task automatic request_refill(input logic [27:0] line);
        @(posedge clk); #1;
        refill_addr = line;
        refill_req  = 1'b1;
        @(posedge clk); #1;
        refill_req  = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk); #2;
        arst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        arst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    int b_wr, b_rd, b_rv, b_pop, b_done;

    initial begin
        arst_n      = 1'b0;
        cke         = 1'b1;
        refill_req  = 1'b0;
        refill_addr = '0;
        wtb_rdata_i = '0;
        be_rdata_i  = '0;
        be_rvalid_i = 1'b0;
        be_ready_i  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk); #1;
        chk("rst_idle",   64'(idle_o),         64'd1);
        chk("rst_avalid", 64'(be_avalid_o),    64'd0);
        chk("rst_busy",   64'(refill_busy_o),  64'd0);
        chk("rst_valid",  64'(refill_valid_o), 64'd0);
        chk("rst_done",   64'(refill_done_o),  64'd0);
        chk("rst_ren",    64'(wtb_ren_o),      64'd0);
        chk("rst_addr",   64'(be_addr_o),      64'd0);
        @(negedge clk); #2;
        arst_n = 1'b1;
        @(posedge clk); #1;

        // 1: three buffered writes, ready always high
        b_wr = wr_n; b_pop = pop_n;
        push(32'h100, 32'hA5A5A5A5, 4'hF);
        push(32'h104, 32'h5A5A5A5A, 4'h3);
        push(32'h108, 32'h12345678, 4'hC);
        wait_wr(b_wr + 3, "t1_wait");
        chk("t1_addr0", 64'(wr_addr[b_wr]),   64'h100);
        chk("t1_data0", 64'(wr_data[b_wr]),   64'hA5A5A5A5);
        chk("t1_strb0", 64'(wr_strb[b_wr]),   64'hF);
        chk("t1_addr1", 64'(wr_addr[b_wr+1]), 64'h104);
        chk("t1_data1", 64'(wr_data[b_wr+1]), 64'h5A5A5A5A);
        chk("t1_strb1", 64'(wr_strb[b_wr+1]), 64'h3);
        chk("t1_addr2", 64'(wr_addr[b_wr+2]), 64'h108);
        chk("t1_data2", 64'(wr_data[b_wr+2]), 64'h12345678);
        chk("t1_strb2", 64'(wr_strb[b_wr+2]), 64'hC);
        chk("t1_cyc0",  64'(wr_cyc[b_wr]   - pop_cyc[b_pop]), 64'd2);
        chk("t1_cyc1",  64'(wr_cyc[b_wr+1] - pop_cyc[b_pop]), 64'd4);
        chk("t1_cyc2",  64'(wr_cyc[b_wr+2] - pop_cyc[b_pop]), 64'd6);
        repeat (2) @(posedge clk); #1;
        chk("t1_pops",  64'(pop_n - b_pop), 64'd3);
        chk("t1_idle",  64'(idle_o),        64'd1);

        // 2: clock enable low blocks the pop, then one write stalled 5 cycles
        cke = 1'b0;
        b_wr = wr_n; b_pop = pop_n;
        push(32'h200, 32'hDEADBEEF, 4'h6);
        @(posedge clk); #1;
        chk("t2_cke_ren", 64'(wtb_ren_o), 64'd0);
        @(posedge clk); #1;
        chk("t2_cke_pop", 64'(pop_n - b_pop), 64'd0);
        stall_n = 5;
        cke = 1'b1;
        wait_wr(b_wr + 1, "t2_wait");
        repeat (3) @(posedge clk); #1;
        chk("t2_hold",   64'(hold_max), 64'd5);
        chk("t2_stable", 64'(hold_bad), 64'd0);
        chk("t2_pops",   64'(pop_n - b_pop), 64'd1);
        chk("t2_addr",   64'(wr_addr[b_wr]), 64'h200);
        chk("t2_data",   64'(wr_data[b_wr]), 64'hDEADBEEF);
        stall_n = 0;

        // 3: refill line 0x40, read data 3 cycles after each accept
        b_rd = rd_n; b_rv = rv_n; b_done = done_n;
        rv_delay = 3;
        request_refill(28'h40);
        chk("t3_busy", 64'(refill_busy_o), 64'd1);
        wait_done(b_done + 1, "t3_wait");
        chk("t3_rd0",   64'(rd_addr[b_rd]),   64'h400);
        chk("t3_rd1",   64'(rd_addr[b_rd+1]), 64'h404);
        chk("t3_rd2",   64'(rd_addr[b_rd+2]), 64'h408);
        chk("t3_rd3",   64'(rd_addr[b_rd+3]), 64'h40C);
        chk("t3_gap",   64'(rd_cyc[b_rd+1] - rd_cyc[b_rd]), 64'd4);
        chk("t3_w0",    64'(rv_word[b_rv]),   64'd0);
        chk("t3_d0",    64'(rv_data[b_rv]),   64'hC0DE0400);
        chk("t3_w3",    64'(rv_word[b_rv+3]), 64'd3);
        chk("t3_d3",    64'(rv_data[b_rv+3]), 64'hC0DE040C);
        chk("t3_done2", 64'(rv_done[b_rv+2]), 64'd0);
        chk("t3_done3", 64'(rv_done[b_rv+3]), 64'd1);
        chk("t3_bsydn", 64'(rv_busy[b_rv+3]), 64'd1);
        repeat (2) @(posedge clk); #1;
        chk("t3_busy_off", 64'(refill_busy_o), 64'd0);
        chk("t3_idle",     64'(idle_o),        64'd1);

        // 4: refill request in the same cycle as two buffered writes
        b_wr = wr_n; b_rd = rd_n; b_done = done_n;
        @(posedge clk); #1;
        push(32'h300, 32'h11111111, 4'hF);
        push(32'h304, 32'h22222222, 4'hF);
        refill_addr = 28'h21;
        refill_req  = 1'b1;
        @(posedge clk); #1;
        refill_req  = 1'b0;
        chk("t4_busy", 64'(refill_busy_o), 64'd1);
        wait_done(b_done + 1, "t4_wait");
        chk("t4_nwr",   64'(wr_n - b_wr), 64'd2);
        chk("t4_order", 64'(wr_cyc[b_wr+1] < rd_cyc[b_rd]), 64'd1);
        chk("t4_rd0",   64'(rd_addr[b_rd]), 64'h210);

        // 5: reset during RD_WAIT abandons the refill; next one restarts at word 0
        b_rd = rd_n; b_rv = rv_n;
        rv_delay = 6;
        request_refill(28'h55);
        wait_rd(b_rd + 2, "t5_wait_rd");
        @(posedge clk); #1;
        chk("t5_pre_busy", 64'(refill_busy_o), 64'd1);
        chk("t5_pre_rv",   64'(rv_n - b_rv),   64'd1);
        #2;
        arst_n = 1'b0;
        #1;
        chk("t5_avalid", 64'(be_avalid_o),    64'd0);
        chk("t5_busy",   64'(refill_busy_o),  64'd0);
        chk("t5_valid",  64'(refill_valid_o), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        arst_n = 1'b1;
        rv_delay = 3;
        b_rd = rd_n; b_rv = rv_n; b_done = done_n;
        request_refill(28'h66);
        wait_done(b_done + 1, "t5_wait");
        chk("t5_rd0", 64'(rd_addr[b_rd]),   64'h660);
        chk("t5_w0",  64'(rv_word[b_rv]),   64'd0);
        chk("t5_d0",  64'(rv_data[b_rv]),   64'hC0DE0660);
        chk("t5_nrv", 64'(rv_n - b_rv),     64'd4);
        chk("t5_w3",  64'(rv_word[b_rv+3]), 64'd3);

`ifdef IOB_CACHE_WTB_DRAIN_PERF_EN
        // 6: performance counters
        pulse_reset();
        chk("t6_rst_wr", 64'(perf_wr_cnt_o), 64'd0);
        b_wr = wr_n; b_done = done_n;
        stall_n = 2;
        push(32'h500, 32'h00000001, 4'hF);
        push(32'h504, 32'h00000002, 4'hF);
        push(32'h508, 32'h00000003, 4'hF);
        push(32'h50C, 32'h00000004, 4'hF);
        wait_wr(b_wr + 4, "t6_wait_wr");
        stall_n = 0;
        request_refill(28'h7);
        wait_done(b_done + 1, "t6_wait");
        repeat (2) @(posedge clk); #1;
        chk("t6_wr",    64'(perf_wr_cnt_o),    64'd4);
        chk("t6_rd",    64'(perf_rd_cnt_o),    64'd1);
        chk("t6_stall", 64'(perf_stall_cnt_o), 64'd8);
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
